// File: rtl/axi_inst_rom_slave.sv
// axi_inst_rom_slave
//   AXI3 read-channel responder that serves instruction fetches from a synchronous
//   single-port ROM/SRAM with a one-cycle read latency. One burst is handled at a time.
//   Each beat goes through FETCH (RAM read), CAPTURE (register the R beat) and RESP
//   (hold the R beat until the master accepts it). FIXED and INCR bursts of 1-256 beats
//   are supported. An unsupported size or burst type still returns every beat, each
//   as SLVERR with zero data, and never reads the RAM.
//
// Ports
//   clk, reset               clock and synchronous active-high reset
//   ARID..ARVALID, ARREADY   AR channel; ARLOCK/ARCACHE/ARPROT are accepted and ignored
//   RID..RVALID, RREADY      R channel; all R outputs are registered
//   ram_en, ram_addr         RAM read request, word address
//   ram_rdata                RAM read data, valid the cycle after ram_en
module axi_inst_rom_slave #(
  parameter int unsigned ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  // AR channel
  input  logic [3:0]            ARID,
  input  logic [31:0]           ARADDR,
  input  logic [7:0]            ARLEN,
  input  logic [2:0]            ARSIZE,
  input  logic [1:0]            ARBURST,
  input  logic [1:0]            ARLOCK,
  input  logic [3:0]            ARCACHE,
  input  logic [2:0]            ARPROT,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  // R channel
  output logic [3:0]            RID,
  output logic [31:0]           RDATA,
  output logic [1:0]            RRESP,
  output logic                  RLAST,
  output logic                  RVALID,
  input  logic                  RREADY,
  // Backing RAM
  output logic                  ram_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [31:0]           ram_rdata
);

  typedef enum logic [1:0] {StIdle, StFetch, StCapture, StResp} state_e;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  state_e                  state_q;
  logic [3:0]              id_q;
  logic [31:0]             addr_q;
  logic [7:0]              len_q;
  logic [7:0]              cnt_q;
  logic                    err_q;
  logic                    fixed_q;

  logic [3:0]              rid_q;
  logic [31:0]             rdata_q;
  logic [1:0]              rresp_q;
  logic                    rlast_q;
  logic                    rvalid_q;
  logic                    ram_en_q;
  logic [ADDR_WIDTH-1:0]   ram_addr_q;

  logic                    ar_hs;
  logic                    r_hs;
  logic                    ar_err;
  logic [31:0]             next_addr;

  // Gated by reset so the master never sees ARREADY while the block is held in reset.
  assign ARREADY = (state_q == StIdle) && !reset;

  assign ar_hs   = ARVALID && ARREADY;
  assign r_hs    = rvalid_q && RREADY;
  assign ar_err  = (ARSIZE != 3'h2) || ARBURST[1];

  // Beat-to-beat address step; wraps at 32 bits with no 4KB boundary handling.
  always_comb begin
    next_addr = addr_q;
    if (!fixed_q) begin
      next_addr = addr_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      fixed_q    <= 1'b0;
      rid_q      <= '0;
      rdata_q    <= '0;
      rresp_q    <= RespOkay;
      rlast_q    <= 1'b0;
      rvalid_q   <= 1'b0;
      ram_en_q   <= 1'b0;
      ram_addr_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ar_hs) begin
            id_q       <= ARID;
            addr_q     <= ARADDR;
            len_q      <= ARLEN;
            cnt_q      <= '0;
            err_q      <= ar_err;
            fixed_q    <= (ARBURST == 2'b00);
            // Issue the first RAM read so it lands in the FETCH cycle.
            ram_en_q   <= !ar_err;
            ram_addr_q <= ARADDR[ADDR_WIDTH+1:2];
            state_q    <= StFetch;
          end
        end
        StFetch: begin
          ram_en_q <= 1'b0;
          state_q  <= StCapture;
        end
        StCapture: begin
          rdata_q  <= err_q ? 32'h0 : ram_rdata;
          rresp_q  <= err_q ? RespSlverr : RespOkay;
          rid_q    <= id_q;
          rlast_q  <= (cnt_q == len_q);
          rvalid_q <= 1'b1;
          state_q  <= StResp;
        end
        StResp: begin
          if (r_hs) begin
            rvalid_q <= 1'b0;
            if (rlast_q) begin
              rlast_q <= 1'b0;
              state_q <= StIdle;
            end else begin
              cnt_q      <= cnt_q + 8'd1;
              addr_q     <= next_addr;
              ram_en_q   <= !err_q;
              ram_addr_q <= next_addr[ADDR_WIDTH+1:2];
              state_q    <= StFetch;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign RID      = rid_q;
  assign RDATA    = rdata_q;
  assign RRESP    = rresp_q;
  assign RLAST    = rlast_q;
  assign RVALID   = rvalid_q;
  assign ram_en   = ram_en_q;
  assign ram_addr = ram_addr_q;

  // Protection/cache/lock attributes carry no meaning for a read-only instruction store.
  logic unused_attr;
  assign unused_attr = ^{ARLOCK, ARCACHE, ARPROT};

endmodule

// File: tb/tb_axi_inst_rom_slave.sv
// Directed bench for axi_inst_rom_slave with a behavioural one-cycle-latency RAM.
module tb_axi_inst_rom_slave;

  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [3:0]    ARID = '0;
  logic [31:0]   ARADDR = '0;
  logic [7:0]    ARLEN = '0;
  logic [2:0]    ARSIZE = 3'h2;
  logic [1:0]    ARBURST = 2'b01;
  logic [1:0]    ARLOCK = '0;
  logic [3:0]    ARCACHE = '0;
  logic [2:0]    ARPROT = '0;
  logic          ARVALID = 1'b0;
  logic          ARREADY;
  logic [3:0]    RID;
  logic [31:0]   RDATA;
  logic [1:0]    RRESP;
  logic          RLAST;
  logic          RVALID;
  logic          RREADY = 1'b0;
  logic          ram_en;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_rdata = '0;

  logic [31:0]   mem [0:(1<<AW)-1];
  int            n_checks = 0;
  int            n_fail = 0;
  int            en_cnt = 0;
  logic [AW-1:0] en_addr [$];

  axi_inst_rom_slave #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT), .ARVALID(ARVALID),
    .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
    .RREADY(RREADY),
    .ram_en(ram_en), .ram_addr(ram_addr), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en) ram_rdata <= mem[ram_addr];
  end

  always @(negedge clk) begin
    if (ram_en) begin
      en_cnt = en_cnt + 1;
      en_addr.push_back(ram_addr);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present an AR request and wait for its handshake; returns just after the handshake edge.
  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    logic ok;
    ok = 1'b0;
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      ok = ARREADY;
      @(posedge clk);
      #1;
    end
    ARVALID = 1'b0;
    check_eq("ar_accept", 32'(ok), 1);
  endtask

  // Wait for an R beat, check it, optionally stall, then accept it.
  task automatic recv_beat(input string tag, input logic [3:0] id, input logic [31:0] data,
                           input logic [1:0] resp, input logic last, input int stall);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (RVALID) break;
    end
    check_eq({tag, "_rvalid"}, 32'(RVALID), 1);
    check_eq({tag, "_rid"}, 32'(RID), 32'(id));
    check_eq({tag, "_rdata"}, RDATA, data);
    check_eq({tag, "_rresp"}, 32'(RRESP), 32'(resp));
    check_eq({tag, "_rlast"}, 32'(RLAST), 32'(last));
    for (int s = 0; s < stall; s++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      check_eq({tag, "_stall_rvalid"}, 32'(RVALID), 1);
      check_eq({tag, "_stall_rdata"}, RDATA, data);
      check_eq({tag, "_stall_rlast"}, 32'(RLAST), 32'(last));
    end
    RREADY = 1'b1;
    @(posedge clk);
    #1;
    RREADY = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = {16'hC0DE, 16'(i)};
    mem[16'h10] = 32'hDEADBEEF;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_arready", 32'(ARREADY), 0);
    check_eq("rst_rvalid", 32'(RVALID), 0);
    check_eq("rst_rlast", 32'(RLAST), 0);
    check_eq("rst_rid", 32'(RID), 0);
    check_eq("rst_rdata", RDATA, 0);
    check_eq("rst_rresp", 32'(RRESP), 0);
    check_eq("rst_ram_en", 32'(ram_en), 0);
    check_eq("rst_ram_addr", 32'(ram_addr), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_eq("post_rst_arready", 32'(ARREADY), 1);

    // Single beat with exact latency
    @(posedge clk);
    #1;
    send_ar(4'd3, 32'h40, 8'd0, 3'h2, 2'b01);
    @(negedge clk);
    check_eq("sb_ram_en_n1", 32'(ram_en), 1);
    check_eq("sb_ram_addr_n1", 32'(ram_addr), 32'h10);
    check_eq("sb_arready_n1", 32'(ARREADY), 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("sb_ram_en_n2", 32'(ram_en), 0);
    check_eq("sb_rvalid_n2", 32'(RVALID), 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("sb_rvalid_n3", 32'(RVALID), 1);
    recv_beat("sb", 4'd3, 32'hDEADBEEF, 2'b00, 1'b1, 0);
    @(negedge clk);
    check_eq("sb_arready_after", 32'(ARREADY), 1);
    check_eq("sb_rvalid_after", 32'(RVALID), 0);

    // INCR 4 beats, beat 2 stalled 5 cycles
    @(posedge clk);
    #1;
    en_addr.delete();
    send_ar(4'd1, 32'h100, 8'd3, 3'h2, 2'b01);
    recv_beat("incr_b1", 4'd1, 32'hC0DE0040, 2'b00, 1'b0, 0);
    recv_beat("incr_b2", 4'd1, 32'hC0DE0041, 2'b00, 1'b0, 5);
    recv_beat("incr_b3", 4'd1, 32'hC0DE0042, 2'b00, 1'b0, 0);
    recv_beat("incr_b4", 4'd1, 32'hC0DE0043, 2'b00, 1'b1, 0);
    check_eq("incr_n_reads", 32'(en_addr.size()), 4);
    for (int i = 0; i < 4 && i < en_addr.size(); i++)
      check_eq("incr_ram_addr", 32'(en_addr[i]), 32'h40 + 32'(i));

    // FIXED 3 beats
    @(posedge clk);
    #1;
    en_addr.delete();
    send_ar(4'd2, 32'h8, 8'd2, 3'h2, 2'b00);
    recv_beat("fix_b1", 4'd2, 32'hC0DE0002, 2'b00, 1'b0, 0);
    recv_beat("fix_b2", 4'd2, 32'hC0DE0002, 2'b00, 1'b0, 0);
    recv_beat("fix_b3", 4'd2, 32'hC0DE0002, 2'b00, 1'b1, 0);
    check_eq("fix_n_reads", 32'(en_addr.size()), 3);
    for (int i = 0; i < en_addr.size(); i++)
      check_eq("fix_ram_addr", 32'(en_addr[i]), 32'h2);

    // Unsupported size: SLVERR beats, no RAM reads
    @(posedge clk);
    #1;
    en_addr.delete();
    send_ar(4'd4, 32'h20, 8'd1, 3'h4, 2'b01);
    recv_beat("err_b1", 4'd4, 32'h0, 2'b10, 1'b0, 0);
    recv_beat("err_b2", 4'd4, 32'h0, 2'b10, 1'b1, 0);
    check_eq("err_no_ram_en", 32'(en_addr.size()), 0);

    // Unsupported burst type (WRAP)
    @(posedge clk);
    #1;
    send_ar(4'd9, 32'h40, 8'd0, 3'h2, 2'b10);
    recv_beat("wrap_b1", 4'd9, 32'h0, 2'b10, 1'b1, 0);
    check_eq("wrap_no_ram_en", 32'(en_addr.size()), 0);

    // Reset mid-burst during RESP of beat 1
    @(posedge clk);
    #1;
    send_ar(4'd6, 32'h200, 8'd3, 3'h2, 2'b01);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (RVALID) break;
    end
    check_eq("mid_rvalid_pre", 32'(RVALID), 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("mid_rvalid", 32'(RVALID), 0);
    check_eq("mid_ram_en", 32'(ram_en), 0);
    check_eq("mid_arready_in_rst", 32'(ARREADY), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    en_addr.delete();
    @(negedge clk);
    check_eq("mid_arready_after", 32'(ARREADY), 1);
    repeat (4) @(posedge clk);
    #1;
    check_eq("mid_no_beats", 32'(RVALID), 0);
    check_eq("mid_no_reads", 32'(en_addr.size()), 0);
    // Upper address bits alias onto the same RAM word
    send_ar(4'd7, 32'h0001_0040, 8'd0, 3'h2, 2'b01);
    recv_beat("mid_fresh", 4'd7, 32'hDEADBEEF, 2'b00, 1'b1, 0);

    // Back-to-back: second AR held during burst 1
    @(posedge clk);
    #1;
    send_ar(4'd8, 32'h0, 8'd1, 3'h2, 2'b01);
    ARID = 4'd5; ARADDR = 32'h44; ARLEN = 8'd0; ARSIZE = 3'h2; ARBURST = 2'b01;
    ARVALID = 1'b1;
    @(negedge clk);
    check_eq("b2b_held_arready", 32'(ARREADY), 0);
    recv_beat("b2b_b1", 4'd8, 32'hC0DE0000, 2'b00, 1'b0, 0);
    @(negedge clk);
    check_eq("b2b_mid_arready", 32'(ARREADY), 0);
    recv_beat("b2b_b2", 4'd8, 32'hC0DE0001, 2'b00, 1'b1, 0);
    @(negedge clk);
    check_eq("b2b_idle_arready", 32'(ARREADY), 1);
    @(posedge clk);
    #1;
    ARVALID = 1'b0;
    @(negedge clk);
    check_eq("b2b_ram_en", 32'(ram_en), 1);
    check_eq("b2b_ram_addr", 32'(ram_addr), 32'h11);
    recv_beat("b2b_2nd", 4'd5, 32'hC0DE0011, 2'b00, 1'b1, 0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axi_inst_rom_slave.md
Name: axi_inst_rom_slave

Overview:
AXI3-style read-channel responder that serves instruction fetches out of a synchronous single-port instruction ROM/SRAM. It is the other end of the CPU's instruction-fetch AXI read master: it accepts AR requests, reads the backing RAM one word per beat, and returns R beats with correct RID, RRESP and RLAST. It supports FIXED and INCR bursts of 1–256 beats. It is non-pipelined: one burst is in flight at a time.

Parameters:
ADDR_WIDTH, 14, word-address width of the backing RAM (RAM depth is 2^ADDR_WIDTH 32-bit words).

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high
ARID  input  4  read transaction ID
ARADDR  input  32  byte address of first beat
ARLEN  input  8  beats minus 1
ARSIZE  input  3  beat size; only 3'h2 (4 bytes) is supported
ARBURST  input  2  0 FIXED, 1 INCR, 2/3 unsupported
ARLOCK  input  2  ignored
ARCACHE  input  4  ignored
ARPROT  input  3  ignored
ARVALID  input  1  address valid
ARREADY  output  1  address ready
RID  output  4  echo of latched ARID
RDATA  output  32  read data
RRESP  output  2  2'b00 OKAY, 2'b10 SLVERR
RLAST  output  1  final beat of burst
RVALID  output  1  read data valid
RREADY  input  1  master ready
ram_en  output  1  RAM read enable
ram_addr  output  ADDR_WIDTH  RAM word address
ram_rdata  input  32  RAM data, valid the cycle after ram_en

Behaviour:
- Reset (synchronous, active-high, clk): state IDLE.
  - ARREADY=0 during reset; ARREADY=1 in the first cycle after reset deasserts.
  - RVALID=0, RLAST=0, RID=0, RDATA=0, RRESP=0, ram_en=0, ram_addr=0; beat counter and latched fields cleared.
  - Reset asserted mid-burst abandons the burst immediately; no further beats are issued.
- State machine: IDLE, FETCH, CAPTURE, RESP.
- IDLE:
  - ARREADY=1.
  - On ARVALID&&ARREADY: latch ARID, ARADDR, ARLEN; set err = (ARSIZE!=3'h2) || (ARBURST[1]==1); beat count=0; go to FETCH. ARREADY drops the next cycle.
- FETCH (1 cycle):
  - ram_en = !err; ram_addr = cur_addr[ADDR_WIDTH+1:2]. Upper address bits are ignored, so addresses alias.
  - Go to CAPTURE.
- CAPTURE (1 cycle):
  - Register RDATA <= err ? 0 : ram_rdata; RRESP <= err ? 2'b10 : 2'b00; RID <= latched ID; RLAST <= (count==len); RVALID <= 1.
  - Go to RESP.
- Latency: AR handshake in cycle N, ram_en in N+1, RVALID first high in N+3. Each subsequent beat takes at least 3 cycles (R handshake in M, next RVALID in M+3).
- RESP:
  - RVALID held high. RID, RDATA, RRESP and RLAST must stay stable until RVALID&&RREADY.
  - On handshake with RLAST=1: RVALID<=0, RLAST<=0, go to IDLE (ARREADY=1 next cycle).
  - On handshake with RLAST=0: RVALID<=0; count<=count+1; cur_addr<=cur_addr+4 for INCR or unchanged for FIXED (32-bit wrap, no 4KB boundary check); go to FETCH.
- ARVALID arriving outside IDLE is not accepted (ARREADY=0) and is held by the master per AXI.
- ARLEN=255 yields exactly 256 beats; the 8-bit counter never overflows before RLAST.
- An error burst still returns ARLEN+1 beats, all SLVERR with RDATA=0, and never pulses ram_en.
- ram_en is high only in FETCH with err=0, for exactly one cycle per beat.

Test Plan:
- Single beat: RAM[0x10]=0xDEADBEEF; AR ID=3, addr=0x40, LEN=0, SIZE=2, INCR -> ram_en in N+1 with ram_addr=0x10; RVALID in N+3 with RDATA=0xDEADBEEF, RID=3, RRESP=0, RLAST=1; ARREADY=1 in the cycle after the R handshake.
- INCR 4-beat with backpressure: addr=0x100, LEN=3; RREADY low for 5 cycles on beat 2 -> ram_addr sequence 0x40,0x41,0x42,0x43; beat 2 data stable throughout the stall; RLAST only on beat 4.
- FIXED burst: addr=0x8, LEN=2, BURST=0 -> three beats, all from ram_addr=0x2; RLAST on beat 3.
- Unsupported request: SIZE=3'h4, LEN=1 -> two beats with RRESP=2'b10, RDATA=0, ram_en never asserted, RLAST on beat 2.
- Reset mid-burst: assert reset during RESP of beat 1 of a LEN=3 burst -> next cycle RVALID=0, ram_en=0; ARREADY=1 after reset deasserts; a fresh single-beat read returns correct data.
- Back-to-back: ARVALID held high with a second request (ID=5) during burst 1 -> second AR accepted only in the IDLE cycle after burst 1's last beat; its beats carry RID=5.
